// File: rtl/sprite_fetcher.sv
// Sprite ROM read initiator: walks a row-major sprite rectangle, hides the
// 1-cycle ROM latency behind a 2-entry FIFO and streams tagged pixels out.
module sprite_fetcher #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int DIM_W      = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [DIM_W-1:0]      spr_w,
  input  logic [DIM_W-1:0]      spr_h,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [WIDTH-1:0]      rom_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [WIDTH-1:0]      pix_data,
  output logic [DIM_W-1:0]      pix_x,
  output logic [DIM_W-1:0]      pix_y,
  output logic                  pix_last
);

  localparam int CNT_W = 2 * DIM_W;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [DIM_W-1:0]      w_q, w_d;
  logic [CNT_W-1:0]      total_q, total_d;
  logic [CNT_W-1:0]      idx_q, idx_d;
  logic [DIM_W-1:0]      fx_q, fx_d;
  logic [DIM_W-1:0]      fy_q, fy_d;
  logic                  inflight_q, inflight_d;
  logic [DIM_W-1:0]      inf_x_q, inf_x_d;
  logic [DIM_W-1:0]      inf_y_q, inf_y_d;
  logic                  inf_last_q, inf_last_d;
  logic                  done_q, done_d;

  logic [1:0][WIDTH-1:0] fifo_data_q, fifo_data_d;
  logic [1:0][DIM_W-1:0] fifo_x_q, fifo_x_d;
  logic [1:0][DIM_W-1:0] fifo_y_q, fifo_y_d;
  logic [1:0]            fifo_last_q, fifo_last_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            count_q, count_d;

  logic       pop;
  logic       push;
  logic [2:0] occ;
  logic       room;
  logic       fire;
  logic       last_issue;

  // A fetch may only be issued if its data is guaranteed a FIFO slot.
  assign pop        = (count_q != 2'd0) && pix_ready;
  assign push       = inflight_q;
  assign occ        = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign room       = occ < 3'd2;
  assign fire       = (state_q == FETCH) && room;
  assign last_issue = (idx_q == total_q - CNT_W'(1));

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    w_d        = w_q;
    total_d    = total_q;
    idx_d      = idx_q;
    fx_d       = fx_q;
    fy_d       = fy_q;
    inflight_d = fire;
    inf_x_d    = inf_x_q;
    inf_y_d    = inf_y_q;
    inf_last_d = inf_last_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if ((spr_w != '0) && (spr_h != '0)) begin
            state_d    = FETCH;
            rom_addr_d = base_addr;
            w_d        = spr_w;
            total_d    = {{DIM_W{1'b0}}, spr_w} * {{DIM_W{1'b0}}, spr_h};
            idx_d      = '0;
            fx_d       = '0;
            fy_d       = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FETCH: begin
        if (fire) begin
          inf_x_d    = fx_q;
          inf_y_d    = fy_q;
          inf_last_d = last_issue;
          if (last_issue) begin
            state_d = DRAIN;
          end else begin
            idx_d      = idx_q + CNT_W'(1);
            rom_addr_d = rom_addr_q + ADDR_WIDTH'(1);
            if (fx_q == w_q - DIM_W'(1)) begin
              fx_d = '0;
              fy_d = fy_q + DIM_W'(1);
            end else begin
              fx_d = fx_q + DIM_W'(1);
            end
          end
        end
      end
      DRAIN: begin
        if (pop && fifo_last_q[rd_ptr_q]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Returning ROM word is written with the tags captured at issue time.
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_x_d    = fifo_x_q;
    fifo_y_d    = fifo_y_q;
    fifo_last_d = fifo_last_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = rom_data;
      fifo_x_d[wr_ptr_q]    = inf_x_q;
      fifo_y_d[wr_ptr_q]    = inf_y_q;
      fifo_last_d[wr_ptr_q] = inf_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      rom_addr_q  <= '0;
      w_q         <= '0;
      total_q     <= '0;
      idx_q       <= '0;
      fx_q        <= '0;
      fy_q        <= '0;
      inflight_q  <= 1'b0;
      inf_x_q     <= '0;
      inf_y_q     <= '0;
      inf_last_q  <= 1'b0;
      done_q      <= 1'b0;
      fifo_data_q <= '0;
      fifo_x_q    <= '0;
      fifo_y_q    <= '0;
      fifo_last_q <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      w_q         <= w_d;
      total_q     <= total_d;
      idx_q       <= idx_d;
      fx_q        <= fx_d;
      fy_q        <= fy_d;
      inflight_q  <= inflight_d;
      inf_x_q     <= inf_x_d;
      inf_y_q     <= inf_y_d;
      inf_last_q  <= inf_last_d;
      done_q      <= done_d;
      fifo_data_q <= fifo_data_d;
      fifo_x_q    <= fifo_x_d;
      fifo_y_q    <= fifo_y_d;
      fifo_last_q <= fifo_last_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign rom_addr  = rom_addr_q;
  assign pix_valid = (count_q != 2'd0);
  assign pix_data  = fifo_data_q[rd_ptr_q];
  assign pix_x     = fifo_x_q[rd_ptr_q];
  assign pix_y     = fifo_y_q[rd_ptr_q];
  assign pix_last  = fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_sprite_fetcher.sv
// Bench for sprite_fetcher: behavioural ROM plus a row-major pixel list
// built from the sprite geometry, checked with immediate assertions.
module tb_sprite_fetcher;

   logic       clk;
   logic       rstn;
   logic       start;
   logic [7:0] base_addr;
   logic [7:0] spr_w;
   logic [7:0] spr_h;
   logic       busy;
   logic       done;
   logic [7:0] rom_addr;
   logic [7:0] rom_data;
   logic       pix_valid;
   logic       pix_ready;
   logic [7:0] pix_data;
   logic [7:0] pix_x;
   logic [7:0] pix_y;
   logic       pix_last;

   int total = 0;
   int bad   = 0;

   logic [7:0] mem [256];

   typedef struct {
      logic [7:0] d;
      logic [7:0] x;
      logic [7:0] y;
      logic       last;
   } pix_t;

   pix_t expQ[$];

   sprite_fetcher #(.WIDTH(8), .DEPTH(256), .DIM_W(8)) dut (
      .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
      .spr_w(spr_w), .spr_h(spr_h), .busy(busy), .done(done),
      .rom_addr(rom_addr), .rom_data(rom_data), .pix_valid(pix_valid),
      .pix_ready(pix_ready), .pix_data(pix_data), .pix_x(pix_x),
      .pix_y(pix_y), .pix_last(pix_last)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous ROM with one registered read cycle; zero while in reset.
   always @(posedge clk) begin
      if (!rstn) rom_data <= 8'h00;
      else       rom_data <= mem[rom_addr];
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Expected pixel stream straight from the geometry: row-major, wrapped address.
   task automatic buildExpected(input logic [7:0] b, input int w, input int h);
      expQ.delete();
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x++) begin
            pix_t p;
            p.d    = mem[(int'(b) + y * w + x) % 256];
            p.x    = 8'(x);
            p.y    = 8'(y);
            p.last = (x == w - 1) && (y == h - 1);
            expQ.push_back(p);
         end
      end
   endtask

   // Runs one command to completion; stallMode 0 holds ready high,
   // 1 randomises ready with occasional 10-cycle stalls.
   task automatic applyStimulus(input logic [7:0] b, input int w, input int h,
                                input int stallMode, input int midStart, input bit checkAhead);
      int   cyc;
      int   accepted;
      int   stallCnt;
      int   n;
      bit   doneExp;
      bit   finished;
      bit   firstSeen;
      bit   prevStall;
      pix_t snap;
      pix_t e;
      logic [7:0] diff;

      buildExpected(b, w, h);
      n         = w * h;
      base_addr = b;
      spr_w     = 8'(w);
      spr_h     = 8'(h);
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      cyc       = 1;
      checkOutput("busy_after_start", 32'(busy), 32'd1);
      checkOutput("rom_addr_first", 32'(rom_addr), 32'(b));

      accepted  = 0;
      stallCnt  = 0;
      doneExp   = 1'b0;
      finished  = 1'b0;
      firstSeen = 1'b0;
      prevStall = 1'b0;
      snap      = '{default: '0};

      while (cyc < 600 && !finished) begin
         checkOutput("done_timing", 32'(done), 32'(doneExp));
         if (doneExp) begin
            checkOutput("busy_after_done", 32'(busy), 32'd0);
            checkOutput("valid_after_done", 32'(pix_valid), 32'd0);
            finished = 1'b1;
         end else begin
            if (cyc == midStart) begin
               start     = 1'b1;
               base_addr = 8'h33;
               spr_w     = 8'd7;
               spr_h     = 8'd6;
            end else begin
               start = 1'b0;
            end

            if (stallMode == 0) begin
               pix_ready = 1'b1;
            end else if (stallCnt > 0) begin
               pix_ready = 1'b0;
               stallCnt--;
            end else if ($urandom_range(7) == 0) begin
               pix_ready = 1'b0;
               stallCnt  = 9;
            end else begin
               pix_ready = 1'($urandom_range(1));
            end

            if (stallMode == 0)
               checkOutput("valid_stream", 32'(pix_valid), 32'((cyc >= 3) && (cyc < 3 + n)));
            if (pix_valid && !firstSeen) begin
               checkOutput("first_valid_cycle", cyc, 3);
               firstSeen = 1'b1;
            end
            if (pix_valid && prevStall) begin
               checkOutput("stall_data", 32'(pix_data), 32'(snap.d));
               checkOutput("stall_x", 32'(pix_x), 32'(snap.x));
               checkOutput("stall_y", 32'(pix_y), 32'(snap.y));
               checkOutput("stall_last", 32'(pix_last), 32'(snap.last));
            end
            if (prevStall)
               checkOutput("valid_held", 32'(pix_valid), 32'd1);
            if (checkAhead && busy) begin
               diff = rom_addr - b;
               checkOutput("addr_ahead", 32'((int'(diff) - accepted) <= 2), 32'd1);
            end

            if (pix_valid && pix_ready) begin
               if (expQ.size() == 0) begin
                  checkOutput("extra_pixel", 32'd1, 32'd0);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("pix_data", 32'(pix_data), 32'(e.d));
                  checkOutput("pix_x", 32'(pix_x), 32'(e.x));
                  checkOutput("pix_y", 32'(pix_y), 32'(e.y));
                  checkOutput("pix_last", 32'(pix_last), 32'(e.last));
                  if (e.last) doneExp = 1'b1;
               end
               accepted++;
            end
            prevStall = pix_valid && !pix_ready;
            snap.d    = pix_data;
            snap.x    = pix_x;
            snap.y    = pix_y;
            snap.last = pix_last;
            @(posedge clk); #1;
            cyc++;
         end
      end
      start = 1'b0;
      if (!finished) checkOutput("cmd_timeout", 32'd1, 32'd0);
      checkOutput("pixels_left", expQ.size(), 0);
      checkOutput("accepted_count", accepted, n);
      @(posedge clk); #1;
      checkOutput("done_single_pulse", 32'(done), 32'd0);
      checkOutput("idle_busy", 32'(busy), 32'd0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
      checkOutput({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
      checkOutput({tag, "_valid"}, 32'(pix_valid), 32'd0);
      checkOutput({tag, "_data"}, 32'(pix_data), 32'd0);
      checkOutput({tag, "_x"}, 32'(pix_x), 32'd0);
      checkOutput({tag, "_y"}, 32'(pix_y), 32'd0);
      checkOutput({tag, "_last"}, 32'(pix_last), 32'd0);
   endtask

   initial begin
      int accepted;
      int guard;

      rstn      = 1'b0;
      start     = 1'b0;
      base_addr = 8'h00;
      spr_w     = 8'd0;
      spr_h     = 8'd0;
      pix_ready = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);

      repeat (3) @(posedge clk);
      #1;
      checkAllZero("reset");
      rstn = 1'b1;
      @(posedge clk); #1;

      $display("[TB] basic 4x2 sprite, identity ROM");
      applyStimulus(8'h10, 4, 2, 0, 0, 1'b0);

      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

      $display("[TB] 3x3 sprite with random backpressure");
      applyStimulus(8'($urandom), 3, 3, 1, 0, 1'b1);
      applyStimulus(8'($urandom), 3, 3, 1, 0, 1'b1);

      $display("[TB] address wrap 4x1 at 0xFE");
      applyStimulus(8'hFE, 4, 1, 0, 0, 1'b0);

      $display("[TB] zero-size command");
      spr_w = 8'd0;
      spr_h = 8'd5;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("zero_done", 32'(done), 32'd1);
      checkOutput("zero_busy", 32'(busy), 32'd0);
      checkOutput("zero_valid", 32'(pix_valid), 32'd0);
      @(posedge clk); #1;
      checkOutput("zero_done_end", 32'(done), 32'd0);
      checkOutput("zero_busy_end", 32'(busy), 32'd0);
      checkOutput("zero_valid_end", 32'(pix_valid), 32'd0);

      $display("[TB] start ignored while busy");
      applyStimulus(8'($urandom), 5, 3, 0, 5, 1'b0);
      applyStimulus(8'($urandom), 2, 4, 1, 4, 1'b0);

      $display("[TB] random shapes");
      for (int k = 0; k < 4; k++)
         applyStimulus(8'($urandom), int'($urandom_range(1, 6)), int'($urandom_range(1, 5)), 1, 0, 1'b0);

      $display("[TB] reset in the middle of a 4x4 command");
      base_addr = 8'($urandom);
      spr_w     = 8'd4;
      spr_h     = 8'd4;
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      accepted  = 0;
      guard     = 0;
      pix_ready = 1'b1;
      while (accepted < 4 && guard < 100) begin
         if (pix_valid && pix_ready) accepted++;
         if (accepted == 4) pix_ready = 1'b0;
         @(posedge clk); #1;
         guard++;
      end
      checkOutput("abort_reached_4", accepted, 4);
      pix_ready = 1'b0;
      @(posedge clk); #1;
      checkOutput("abort_5th_valid", 32'(pix_valid), 32'd1);
      rstn = 1'b0;
      @(posedge clk); #1;
      checkAllZero("abort");
      rstn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checkOutput("abort_no_done", 32'(done), 32'd0);
         checkOutput("abort_no_valid", 32'(pix_valid), 32'd0);
      end

      applyStimulus(8'($urandom), 2, 2, 0, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop in case a wait above ever misbehaves.
   initial begin
      #500000;
      $display("[TB] FAIL global_timeout observed=running expected=finished");
      $fatal(1, "[TB] global timeout");
   end

endmodule

// File: doc/sprite_fetcher.md
Name: sprite_fetcher

Overview:
Read-side initiator for the synchronous sprite ROMs. The ROMs have 1-cycle registered read latency and zero output while in reset. On a start command this block walks a rectangular sprite stored row-major at a base address. It issues ROM addresses, absorbs the read latency, and streams pixels with x/y coordinates to the renderer over a valid/ready handshake with full backpressure. It sits between the sprite ROM and the pixel compositor.

Parameters:
WIDTH, 8, pixel data width; must match the ROM data width.
DEPTH, 256, ROM depth in words.
ADDR_WIDTH, $clog2(DEPTH), ROM address width (derived).
DIM_W, 8, width of the sprite dimension and coordinate fields.

Ports:
clk  in  1  clock.
rstn  in  1  reset, synchronous, active-low.
start  in  1  one-cycle command strobe; sampled only in IDLE.
base_addr  in  ADDR_WIDTH  ROM address of pixel (0,0).
spr_w  in  DIM_W  sprite width in pixels.
spr_h  in  DIM_W  sprite height in pixels.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  one-cycle pulse at end of command.
rom_addr  out  ADDR_WIDTH  registered address to the ROM.
rom_data  in  WIDTH  ROM output; equals mem[rom_addr of the previous cycle].
pix_valid  out  1  pixel available.
pix_ready  in  1  consumer accepts pixel.
pix_data  out  WIDTH  pixel value.
pix_x  out  DIM_W  column of the pixel, 0..spr_w-1.
pix_y  out  DIM_W  row of the pixel, 0..spr_h-1.
pix_last  out  1  high with the final pixel of the command.

Behaviour:
- Reset (rstn low at posedge): state IDLE; all counters cleared; 2-entry output FIFO emptied; in-flight flag cleared.
  - Output values under reset: busy=0, done=0, rom_addr=0, pix_valid=0, pix_data=0, pix_x=0, pix_y=0, pix_last=0.
  - Reset mid-command aborts the command; no done pulse is generated.
- Handshake: a transfer occurs on any posedge where pix_valid && pix_ready.
  - pix_data, pix_x, pix_y and pix_last hold stable while pix_valid && !pix_ready.
  - pix_valid never drops without a transfer.
- State IDLE:
  - start with spr_w!=0 and spr_h!=0: latch base_addr, spr_w and spr_h; go to FETCH; busy=1 from the next cycle.
  - start with spr_w==0 or spr_h==0: pulse done the next cycle; no fetch; busy stays 0.
- State FETCH: a fetch is issued in a cycle when rom_addr holds the target address and the issue flag is set.
  - Issue rule: issue only if (fifo_count + inflight - pop) < 2, where pop = this cycle's transfer.
  - Issued address = (latched base + linear index) mod DEPTH; wrap-around is legal.
  - rom_data is captured into the FIFO one cycle after issue, tagged with its x/y and last flag.
  - rom_addr holds its value when not issuing.
  - After spr_w*spr_h fetches have been issued, go to DRAIN.
- State DRAIN: when the last pixel transfers, go to IDLE, with done=1 and busy=0 in the following cycle.
- Latency and throughput:
  - start sampled at edge 0 → rom_addr=base at cycle 1 → pix_valid first high in cycle 3.
  - With pix_ready held high: one pixel per cycle; done pulses the cycle after the last transfer.
- Ordering: row-major. x increments; at x=spr_w-1, x goes to 0 and y increments.
- start while busy: ignored; no effect on the current command.
- Arithmetic: index counter width = 2*DIM_W, so there is no overflow. Address addition truncates to ADDR_WIDTH.

Test Plan:
- Basic 4x2 sprite, base=0x10, ROM mem[i]=i, pix_ready=1 → 8 pixels in consecutive cycles from cycle 3.
  - Data 0x10..0x17 with (x,y) = (0,0)..(3,0),(0,1)..(3,1).
  - pix_last only on data 0x17; done in the cycle after; busy low again.
- Backpressure: 3x3 sprite, pix_ready toggled pseudo-randomly, including 10-cycle stalls → all 9 pixels in order, none duplicated or lost, outputs stable during stalls.
  - rom_addr never more than 2 ahead of the last accepted pixel.
- Address wrap: DEPTH=256, base=0xFE, 4x1 → data from addresses 0xFE, 0xFF, 0x00, 0x01.
- Zero size: start with spr_w=0, spr_h=5 → done one cycle later; no pix_valid; busy stays 0.
- start ignored while busy: second start mid-command with different parameters → only the first command's pixels are produced; a single done pulse.
- Reset mid-command: rstn low during the 5th pixel of 4x4 with pix_ready=0 → all outputs 0 next cycle; no done.
  - A new 2x2 command after release completes correctly.
